label_scan_ctrl: RTL and testbench
==================================

Name: label_scan_ctrl

Overview:
- Raster-scan sequencer for the 1st-pass connected-component labeler in the bounding-box path.
- Accepts the binary motion-pixel stream and tracks column and row position. Supplies the left and top neighbour labels from a row line buffer, and drives enable and last_in_frame to the labeler.
- Registers each assigned label onto an output stream.
- At frame end, hands off to the equivalence resolver and holds input until the resolver finishes.

Parameters:
- LABEL_WIDTH, 8, label bit width; must match the labeler instance.
- IMG_WIDTH, 320, pixels per row (>=2).
- IMG_HEIGHT, 240, rows per frame (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; arms scanning of the next frame
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  input pixel accepted when pix_valid && pix_ready
- pix_motion  in  1  motion bit of the current pixel
- lab_enable  out  1  to labeler enable
- lab_motion  out  1  to labeler motion_pixel
- lab_left  out  LABEL_WIDTH  to labeler left_label
- lab_top  out  LABEL_WIDTH  to labeler top_label
- lab_last_in_frame  out  1  to labeler last_in_frame
- lab_current_label  in  LABEL_WIDTH  from labeler current_label (combinational)
- lab_new_label_valid  in  1  from labeler
- lab_new_label_value  in  LABEL_WIDTH  from labeler
- lbl_valid  out  1  labeled pixel valid
- lbl_ready  in  1  downstream ready
- lbl_label  out  LABEL_WIDTH  registered label
- lbl_x  out  $clog2(IMG_WIDTH)  column of lbl_label
- lbl_y  out  $clog2(IMG_HEIGHT)  row of lbl_label
- lbl_eof  out  1  marks the last pixel of the frame
- resolve_start  out  1  one-cycle pulse to the equivalence resolver
- resolve_done  in  1  resolver finished (pulse or level)
- busy  out  1  high when state != IDLE
- lbl_overflow  out  1  see Optional Feature

Behaviour:
- Reset values:
  - state=IDLE; x=0, y=0.
  - left_reg=0; all line buffer entries=0.
  - All outputs 0; lbl_* = 0.
- FSM:
  - IDLE -> SCAN when start=1; x and y are cleared on that transition.
  - SCAN -> RESOLVE on acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
  - RESOLVE: resolve_start pulses for exactly the first cycle in this state.
  - RESOLVE -> IDLE when resolve_done=1 and start=0.
  - RESOLVE -> SCAN when resolve_done=1 and start=1, giving back-to-back frames.
  - resolve_done is ignored outside RESOLVE.
- pix_ready = (state==SCAN) && (!lbl_valid || lbl_ready).
- accept = pix_valid && pix_ready.
- lab_enable=accept and lab_motion=pix_motion, both combinational.
- lab_left = (x==0) ? 0 : left_reg.
- lab_top = (y==0) ? 0 : linebuf[x], read combinationally. The stale previous-frame row is therefore masked, and the buffer needs no clearing.
- lab_last_in_frame = accept && x==IMG_WIDTH-1 && y==IMG_HEIGHT-1.
- On accept, all in the same clock:
  - left_reg <= lab_current_label.
  - linebuf[x] <= lab_current_label.
  - lbl_label/lbl_x/lbl_y <= current values; lbl_eof <= lab_last_in_frame; lbl_valid <= 1.
  - x increments. When x wraps to 0, y increments. On the last pixel, y wraps to 0.
- Non-motion pixels write label 0.
- Latency: one cycle from accept to lbl_valid.
- lbl_valid clears when lbl_ready=1 and there is no accept.
- Output stability: while lbl_valid && !lbl_ready, all lbl_* outputs hold and pix_ready=0.
- Reset mid-frame: immediate return to IDLE with counters zeroed. The labeler is reset by the same rst.

Optional Feature:
- Macro LABEL_SCAN_OVF_EN.
- Defined:
  - lbl_overflow is sticky high once lab_new_label_valid && lab_new_label_value==0 occurs during SCAN, which indicates the label space is exhausted.
  - Cleared on the IDLE->SCAN or RESOLVE->SCAN transition.
  - Its value persists through RESOLVE so the resolver can read it.
- Undefined: lbl_overflow tied to 0; no flop is synthesised.

Decomposition:
- Shared package label_pkg:
  - Default LABEL_WIDTH.
  - scan_state_t enum {IDLE, SCAN, RESOLVE}.
  - Label-zero constant LABEL_NONE.
- Sub-module label_line_buffer: IMG_WIDTH x LABEL_WIDTH register array with one asynchronous read port and one synchronous write port; reset clears all entries.
- Controller FSM, counters and output register stay in label_scan_ctrl.

Test Plan:
- Reset checks (IMG_WIDTH=4, IMG_HEIGHT=3, paired with the labeler):
  - Stimulus: assert rst mid-frame at x=2, y=1.
  - Required: pix_ready=0, busy=0, lbl_valid=0 the same cycle. After release and start, the first accepted pixel reports x=0, y=0.
- Isolated pixel:
  - Stimulus: motion only at (1,1).
  - Required: lab_left=0 and lab_top=0 on that pixel. lbl_label=1 at lbl_x=1, lbl_y=1 one cycle later; all other labels 0.
- Full first row, then merge:
  - Stimulus: row0 all motion, row1 all zero, row2 = {1,0,1,1}.
  - Required: row0 labels {1,1,1,1}; row2 labels {2,0,3,3}. lab_top=0 for every row2 pixel.
- Backpressure:
  - Stimulus: hold lbl_ready=0 for 3 cycles after the first output.
  - Required: pix_ready=0 for those 3 cycles, and lbl_label/lbl_x/lbl_y unchanged. No pixel is lost after release.
- Frame end:
  - Stimulus: accept pixel (3,2).
  - Required: lab_last_in_frame=1 and lbl_eof=1 next cycle. resolve_start pulses once. pix_ready stays 0 until resolve_done. With start=1, the FSM returns to SCAN and the next frame's first pixel sees lab_top=0.
- Overflow (LABEL_SCAN_OVF_EN defined, LABEL_WIDTH=2):
  - Stimulus: 4 isolated pixels in one frame.
  - Required: labels 1,2,3,0, and lbl_overflow rises on the 4th pixel. lbl_overflow clears on the next frame start.

Source files
------------

// File: rtl/label_pkg.sv
// Shared types and constants for the connected-component labeling path.
// Holds the scan sequencer state encoding, default label width and the
// reserved "no label" value used for background pixels and masked neighbours.
package label_pkg;

    // Default label width; the labeler instance must use the same value.
    localparam int LABEL_WIDTH_DEF = 8;

    // Label value reserved for background / absent neighbour.
    localparam int LABEL_NONE = 0;

    // Raster-scan sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        RESOLVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/label_line_buffer.sv
// Purpose: one-row label store giving the labeler its top neighbour.
// Latency: read is combinational; a write is visible the cycle after it.
// Backpressure: none; the write enable is owned entirely by the caller.
module label_line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage: cleared on reset, one entry written per accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/label_scan_ctrl.sv
// Purpose: raster-scan sequencer feeding the first-pass labeler, with resolver hand-off.
// Latency: one cycle from pixel acceptance to lbl_valid.
// Backpressure: pix_ready drops while a held label is not taken and outside SCAN.
// Build option: LABEL_SCAN_OVF_EN adds a sticky label-space-exhausted flag.
module label_scan_ctrl
    import label_pkg::*;
#(
    parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
    parameter int IMG_WIDTH   = 320,
    parameter int IMG_HEIGHT  = 240,
    localparam int XW         = $clog2(IMG_WIDTH),
    localparam int YW         = $clog2(IMG_HEIGHT)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic                   pix_motion,
    output logic                   lab_enable,
    output logic                   lab_motion,
    output logic [LABEL_WIDTH-1:0] lab_left,
    output logic [LABEL_WIDTH-1:0] lab_top,
    output logic                   lab_last_in_frame,
    input  logic [LABEL_WIDTH-1:0] lab_current_label,
    input  logic                   lab_new_label_valid,
    input  logic [LABEL_WIDTH-1:0] lab_new_label_value,
    output logic                   lbl_valid,
    input  logic                   lbl_ready,
    output logic [LABEL_WIDTH-1:0] lbl_label,
    output logic [XW-1:0]          lbl_x,
    output logic [YW-1:0]          lbl_y,
    output logic                   lbl_eof,
    output logic                   resolve_start,
    input  logic                   resolve_done,
    output logic                   busy,
    output logic                   lbl_overflow
);

    scan_state_t            r_state;
    logic [XW-1:0]          r_x;
    logic [YW-1:0]          r_y;
    logic [LABEL_WIDTH-1:0] r_left;
    logic                   r_resolve_start;

    logic                   r_lbl_valid;
    logic [LABEL_WIDTH-1:0] r_lbl_label;
    logic [XW-1:0]          r_lbl_x;
    logic [YW-1:0]          r_lbl_y;
    logic                   r_lbl_eof;

    logic                   w_accept;
    logic                   w_last_x;
    logic                   w_last_y;
    logic                   w_last_pix;
    logic [LABEL_WIDTH-1:0] w_top_raw;
    logic [LABEL_WIDTH-1:0] w_wr_label;

    assign w_last_x   = (r_x == XW'(IMG_WIDTH - 1));
    assign w_last_y   = (r_y == YW'(IMG_HEIGHT - 1));
    assign pix_ready  = (r_state == SCAN) && (!r_lbl_valid || lbl_ready);
    assign w_accept   = pix_valid && pix_ready;
    assign w_last_pix = w_accept && w_last_x && w_last_y;

    // Background pixels always store the empty label, whatever the labeler reports.
    assign w_wr_label = pix_motion ? lab_current_label : LABEL_WIDTH'(LABEL_NONE);

    assign lab_enable        = w_accept;
    assign lab_motion        = pix_motion;
    assign lab_last_in_frame = w_last_pix;
    // Column 0 has no left neighbour; row 0 must not see last frame's bottom row.
    assign lab_left          = (r_x == '0) ? '0 : r_left;
    assign lab_top           = (r_y == '0) ? '0 : w_top_raw;

    assign busy          = (r_state != IDLE);
    assign resolve_start = r_resolve_start;

    assign lbl_valid = r_lbl_valid;
    assign lbl_label = r_lbl_label;
    assign lbl_x     = r_lbl_x;
    assign lbl_y     = r_lbl_y;
    assign lbl_eof   = r_lbl_eof;

    label_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (LABEL_WIDTH)
    ) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_x),
        .i_wr_dat  (w_wr_label),
        .i_rd_addr (r_x),
        .o_rd_dat  (w_top_raw)
    );

    // Frame sequencing: state, raster position and the one-cycle resolver kick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_x             <= '0;
            r_y             <= '0;
            r_resolve_start <= 1'b0;
        end else begin
            r_resolve_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SCAN;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                SCAN: begin
                    if (w_accept) begin
                        if (w_last_x) begin
                            r_x <= '0;
                            if (w_last_y) begin
                                r_y             <= '0;
                                r_state         <= RESOLVE;
                                r_resolve_start <= 1'b1;
                            end else begin
                                r_y <= r_y + YW'(1);
                            end
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                RESOLVE: begin
                    if (resolve_done) begin
                        r_state <= start ? SCAN : IDLE;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Left neighbour is simply the label just written in this row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left <= '0;
        end else if (w_accept) begin
            r_left <= w_wr_label;
        end
    end

    // Output register: loads on accept, drains when taken with nothing new behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lbl_valid <= 1'b0;
            r_lbl_label <= '0;
            r_lbl_x     <= '0;
            r_lbl_y     <= '0;
            r_lbl_eof   <= 1'b0;
        end else if (w_accept) begin
            r_lbl_valid <= 1'b1;
            r_lbl_label <= w_wr_label;
            r_lbl_x     <= r_x;
            r_lbl_y     <= r_y;
            r_lbl_eof   <= w_last_pix;
        end else if (lbl_ready) begin
            r_lbl_valid <= 1'b0;
        end
    end

`ifdef LABEL_SCAN_OVF_EN
    logic r_overflow;
    logic w_enter_scan;

    assign w_enter_scan = start && (((r_state == IDLE)) ||
                                    ((r_state == RESOLVE) && resolve_done));

    // Sticky exhaustion flag: a freshly allocated label of zero means the space wrapped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_enter_scan) begin
            r_overflow <= 1'b0;
        end else if ((r_state == SCAN) && lab_new_label_valid &&
                     (lab_new_label_value == LABEL_WIDTH'(LABEL_NONE))) begin
            r_overflow <= 1'b1;
        end
    end

    assign lbl_overflow = r_overflow;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = ^{lab_new_label_valid, lab_new_label_value};
    assign lbl_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_label_scan_ctrl.sv
// Bench for label_scan_ctrl on a 4x3 image with 2-bit labels, driven against a
// small first-pass labeler stand-in and a frame-level reference model.
module tb_label_scan_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int LW = 2;
    localparam int XW = 2;
    localparam int YW = 2;
`ifdef LABEL_SCAN_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start, pix_valid, pix_ready, pix_motion;
    logic          lab_enable, lab_motion, lab_last_in_frame;
    logic [LW-1:0] lab_left, lab_top, lab_current_label, lab_new_label_value;
    logic          lab_new_label_valid;
    logic          lbl_valid, lbl_ready, lbl_eof;
    logic [LW-1:0] lbl_label;
    logic [XW-1:0] lbl_x;
    logic [YW-1:0] lbl_y;
    logic          resolve_start, resolve_done, busy, lbl_overflow;

    always #5 clk = ~clk;

    label_scan_ctrl #(.LABEL_WIDTH(LW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_motion(pix_motion),
        .lab_enable(lab_enable), .lab_motion(lab_motion), .lab_left(lab_left),
        .lab_top(lab_top), .lab_last_in_frame(lab_last_in_frame),
        .lab_current_label(lab_current_label),
        .lab_new_label_valid(lab_new_label_valid),
        .lab_new_label_value(lab_new_label_value),
        .lbl_valid(lbl_valid), .lbl_ready(lbl_ready), .lbl_label(lbl_label),
        .lbl_x(lbl_x), .lbl_y(lbl_y), .lbl_eof(lbl_eof),
        .resolve_start(resolve_start), .resolve_done(resolve_done),
        .busy(busy), .lbl_overflow(lbl_overflow)
    );

    // Labeler stand-in: prefer left, then top, else allocate the next label.
    logic [LW-1:0] r_next;
    logic          w_alloc;
    always_comb begin
        lab_current_label   = '0;
        w_alloc             = 1'b0;
        if (lab_motion) begin
            if (lab_left != '0)     lab_current_label = lab_left;
            else if (lab_top != '0) lab_current_label = lab_top;
            else begin
                lab_current_label = r_next;
                w_alloc           = 1'b1;
            end
        end
        lab_new_label_valid = lab_enable && w_alloc;
        lab_new_label_value = r_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   r_next <= 2'd1;
        else if (lab_enable && lab_last_in_frame)  r_next <= 2'd1;
        else if (lab_new_label_valid)              r_next <= r_next + 2'd1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef struct { int l; int x; int y; int e; } exp_t;
    exp_t q[$];
    int   st;              // 0 idle, 1 scan, 2 resolve
    int   rs_cyc;
    int   fx, fy, next_lbl;
    bit   ovf_m;
    int   lab [H][W];
    bit   pm [H][W];
    int   dut_lab [H][W];

    task automatic model_reset();
        q.delete();
        st = 0; rs_cyc = 0; fx = 0; fy = 0; next_lbl = 1; ovf_m = 1'b0;
    endtask

    // One clock: drive at negedge, check 1 ns later, advance model, wait next negedge.
    task automatic cyc(input bit v, input bit rdy, input bit st_in, input bit done_in);
        int left, top, lbl, st_old;
        bit mot, acc, last, exp_rdy;
        st_old = st;
        mot = (v && st == 1) ? pm[fy][fx] : 1'($urandom_range(0, 1));
        pix_valid = v; pix_motion = mot; lbl_ready = rdy;
        start = st_in; resolve_done = done_in;
        #1;
        check("busy", busy, st != 0);
        check("lbl_valid", lbl_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("lbl_label", lbl_label, q[0].l);
            check("lbl_x", lbl_x, q[0].x);
            check("lbl_y", lbl_y, q[0].y);
            check("lbl_eof", lbl_eof, q[0].e);
        end
        check("resolve_start", resolve_start, st == 2 && rs_cyc == 0);
        check("lbl_overflow", lbl_overflow, OVF ? ovf_m : 1'b0);
        exp_rdy = (st == 1) && (q.size() == 0 || rdy);
        check("pix_ready", pix_ready, exp_rdy);
        acc = v && exp_rdy;
        check("lab_enable", lab_enable, acc);
        if (q.size() != 0 && rdy) begin
            dut_lab[q[0].y][q[0].x] = lbl_label;
            void'(q.pop_front());
        end
        if (acc) begin
            left = (fx > 0) ? lab[fy][fx-1] : 0;
            top  = (fy > 0) ? lab[fy-1][fx] : 0;
            last = (fx == W-1) && (fy == H-1);
            check("lab_left", lab_left, left);
            check("lab_top", lab_top, top);
            check("lab_last_in_frame", lab_last_in_frame, last);
            if (!mot)           lbl = 0;
            else if (left != 0) lbl = left;
            else if (top != 0)  lbl = top;
            else begin
                lbl = next_lbl % (1 << LW);
                next_lbl++;
                if (lbl == 0) ovf_m = 1'b1;
            end
            lab[fy][fx] = lbl;
            q.push_back('{lbl, fx, fy, int'(last)});
            if (last) begin
                fx = 0; fy = 0; st = 2; rs_cyc = 0; next_lbl = 1;
            end else if (fx == W-1) begin
                fx = 0; fy++;
            end else begin
                fx++;
            end
        end else begin
            check("lab_last_in_frame_idle", lab_last_in_frame, 0);
        end
        if (st_old == 0 && st_in) begin
            st = 1; fx = 0; fy = 0; ovf_m = 1'b0;
        end else if (st_old == 2 && done_in) begin
            st = st_in ? 1 : 0;
            if (st_in) ovf_m = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (st_old == 2 && st == 2) rs_cyc++;
    endtask

    // mode 0: free flowing; 1: three cycles of output stall; 2: random valid/ready/noise.
    task automatic run_frame(input int mode);
        int guard = 0;
        int hold  = 0;
        bit v, r, s, d;
        while (st == 1 && guard < 500) begin
            v = 1'b1; r = 1'b1; s = 1'b0; d = 1'b0;
            if (mode == 1 && q.size() != 0 && hold < 3) begin
                r = 1'b0; hold++;
            end
            if (mode == 2) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) != 0);
                s = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
            end
            cyc(v, r, s, d);
            guard++;
        end
        check("frame_completes", guard < 500, 1);
    endtask

    task automatic finish_frame(input bit next_start, input int waits);
        for (int i = 0; i < waits; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, next_start, 1'b1);
    endtask

    task automatic start_frame();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic clear_pm();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                pm[y][x] = 1'b0; dut_lab[y][x] = -1;
            end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_motion = 1'b0;
        lbl_ready = 1'b0; resolve_done = 1'b0;
        model_reset();
        clear_pm();
        @(negedge clk);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_lbl_valid", lbl_valid, 0);
        check("rst_lbl_label", lbl_label, 0);
        check("rst_lbl_xy", {lbl_x, lbl_y}, 0);
        check("rst_resolve_start", resolve_start, 0);
        check("rst_lbl_overflow", lbl_overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);

        // Isolated pixel at (1,1).
        clear_pm();
        pm[1][1] = 1'b1;
        start_frame();
        run_frame(0);
        finish_frame(1'b1, 2);
        check("iso_label", dut_lab[1][1], 1);
        check("iso_bg", dut_lab[0][1], 0);

        // Full row, empty row, then {1,0,1,1} with output stall.
        clear_pm();
        for (int x = 0; x < W; x++) pm[0][x] = 1'b1;
        pm[2][0] = 1'b1; pm[2][2] = 1'b1; pm[2][3] = 1'b1;
        run_frame(1);
        finish_frame(1'b1, 1);
        for (int x = 0; x < W; x++) check("row0_label", dut_lab[0][x], 1);
        check("row2_x0", dut_lab[2][0], 2);
        check("row2_x1", dut_lab[2][1], 0);
        check("row2_x2", dut_lab[2][2], 3);
        check("row2_x3", dut_lab[2][3], 3);

        // Label-space exhaustion: four isolated pixels.
        clear_pm();
        pm[0][0] = 1'b1; pm[0][2] = 1'b1; pm[1][1] = 1'b1; pm[1][3] = 1'b1;
        run_frame(0);
        finish_frame(1'b0, 3);
        check("ovf_l1", dut_lab[0][0], 1);
        check("ovf_l2", dut_lab[0][2], 2);
        check("ovf_l3", dut_lab[1][1], 3);
        check("ovf_l4", dut_lab[1][3], 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);

        // Random frames with random flow control and out-of-state noise.
        for (int f = 0; f < 8; f++) begin
            if (st == 0) start_frame();
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) pm[y][x] = ($urandom_range(0, 2) == 0);
            run_frame(2);
            finish_frame(1'($urandom_range(0, 1)), $urandom_range(1, 4));
        end

        // Reset in the middle of a frame at (2,1).
        if (st == 0) start_frame();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) pm[y][x] = 1'($urandom_range(0, 1));
        for (int g = 0; g < 50 && !(fx == 2 && fy == 1); g++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_pix_ready", pix_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_lbl_valid", lbl_valid, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_frame();
        run_frame(0);
        finish_frame(1'b0, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
